// File: rtl/hd_sync_if.sv
// HD raster bundle between the sync generator and its consumers.
// Carries the PAL frame-end pulse in and the HD timing signals out.
interface hd_sync_if;
    logic        i_frame_end;
    logic        o_hd_clk;
    logic        o_hd_hsync;
    logic        o_hd_vsync;
    logic        o_hd_de;
    logic [11:0] o_h_count;
    logic [10:0] o_v_count;
    logic        o_frame_start;
    logic        o_locked;

    modport master (
        input  i_frame_end,
        output o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
        output o_h_count, o_v_count, o_frame_start, o_locked
    );

    modport slave (
        output i_frame_end,
        input  o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
        input  o_h_count, o_v_count, o_frame_start, o_locked
    );
endinterface

// File: rtl/hd_sync_gen.sv
// HD raster timing generator with optional vertical genlock
// to the PAL frame-end pulse of the upsampler.
module hd_sync_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter bit GENLOCK_EN = 1'b1,
    parameter int LOCK_LINE  = 0
) (
    input logic       clk,
    input logic       i_rst,
    hd_sync_if.master hd
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, PENDING} gl_state_t;

    gl_state_t   state;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [11:0] h_count;
    logic [10:0] v_count;
    logic [10:0] v_nat;
    logic [10:0] v_nxt;
    logic [1:0]  lock_cnt;
    logic        pix_en;
    logic        line_wrap;
    logic        apply;
    logic        hit;
    logic        wrap_q;

    // Next-state terms shared by the counters and the genlock FSM
    always_comb begin
        pix_en    = (div_cnt == DW'(CLK_DIV - 1));
        div_nxt   = pix_en ? '0 : div_cnt + DW'(1);
        line_wrap = pix_en && (h_count == 12'(H_TOTAL - 1));
        v_nat     = (v_count == 11'(V_TOTAL - 1)) ? '0
                                                  : v_count + 11'd1;
        apply     = line_wrap && (state == PENDING);
        hit       = (v_nat == 11'(LOCK_LINE));
        v_nxt     = (apply && !hit) ? 11'(LOCK_LINE) : v_nat;
    end

    // Pixel divider and raster counters; genlock only moves v at a line wrap
    always_ff @(posedge clk) begin
        if (i_rst) begin
            div_cnt <= '0;
            h_count <= '0;
            v_count <= '0;
            wrap_q  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            wrap_q  <= line_wrap && (v_nxt == '0);
            if (pix_en) begin
                h_count <= line_wrap ? '0 : h_count + 12'd1;
                if (line_wrap) v_count <= v_nxt;
            end
        end
    end

    // Genlock: latch a frame-end, resolve it at the next line wrap
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hd.i_frame_end && GENLOCK_EN) state <= PENDING;
                end
                PENDING: begin
                    if (line_wrap) begin
                        state <= IDLE;
                        if (hit) begin
                            if (lock_cnt != 2'd3) lock_cnt <= lock_cnt + 2'd1;
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    // Registered decode of the raster position into HD timing outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            hd.o_hd_clk      <= 1'b1;
            hd.o_hd_hsync    <= ~HS_POL;
            hd.o_hd_vsync    <= ~VS_POL;
            hd.o_hd_de       <= 1'b0;
            hd.o_h_count     <= '0;
            hd.o_v_count     <= '0;
            hd.o_frame_start <= 1'b0;
            hd.o_locked      <= 1'b0;
        end else begin
            hd.o_hd_clk   <= (div_nxt < DW'(CLK_DIV / 2));
            hd.o_hd_de    <= (h_count < 12'(H_ACTIVE))
                          && (v_count < 11'(V_ACTIVE));
            hd.o_hd_hsync <= ((h_count >= 12'(HS_START))
                          && (h_count < 12'(HS_END))) ? HS_POL : ~HS_POL;
            hd.o_hd_vsync <= ((v_count >= 11'(VS_START))
                          && (v_count < 11'(VS_END))) ? VS_POL : ~VS_POL;
            hd.o_h_count     <= h_count;
            hd.o_v_count     <= v_count;
            hd.o_frame_start <= wrap_q;
            hd.o_locked      <= (lock_cnt == 2'd3);
        end
    end
endmodule

// File: tb/tb_hd_sync_gen.sv
// Bench for hd_sync_gen: small 24x12 raster, genlock jumps,
// lock convergence, divider pattern and mid-line reset.
module tb_hd_sync_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe  = 1'b0;

    always #5 clk = ~clk;

    hd_sync_if bus_a ();
    hd_sync_if bus_b ();
    assign bus_a.i_frame_end = fe;
    assign bus_b.i_frame_end = fe;

    hd_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .GENLOCK_EN(1'b1), .LOCK_LINE(0)
    ) dut_a (.clk(clk), .i_rst(rst), .hd(bus_a));

    hd_sync_gen #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .GENLOCK_EN(1'b0), .LOCK_LINE(0)
    ) dut_b (.clk(clk), .i_rst(rst), .hd(bus_b));

    // {hd_clk, hsync, vsync, de, frame_start, locked, h[11:0], v[10:0]}
    logic [28:0] obs_a;
    logic [28:0] obs_b;
    assign obs_a = {bus_a.o_hd_clk, bus_a.o_hd_hsync, bus_a.o_hd_vsync,
                    bus_a.o_hd_de, bus_a.o_frame_start, bus_a.o_locked,
                    bus_a.o_h_count, bus_a.o_v_count};
    assign obs_b = {bus_b.o_hd_clk, bus_b.o_hd_hsync, bus_b.o_hd_vsync,
                    bus_b.o_hd_de, bus_b.o_frame_start, bus_b.o_locked,
                    bus_b.o_h_count, bus_b.o_v_count};

    typedef struct {
        int          k;
        bit          dut_b;
        bit          fe;
        bit          chk;
        logic [28:0] exp;
        logic [28:0] msk;
        string       tag;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Build a vector; a negative field value means "don't care"
    function automatic vec_t V(int k, string tag, int h, int v, int hc,
                               int hs, int vs, int de, int fs, int lk,
                               bit b = 1'b0, bit f = 1'b0);
        vec_t r;
        int   fl[6];
        r.k = k; r.tag = tag; r.dut_b = b; r.fe = f;
        r.exp = '0; r.msk = '0;
        if (h >= 0) begin r.exp[22:11] = 12'(h); r.msk[22:11] = '1; end
        if (v >= 0) begin r.exp[10:0] = 11'(v); r.msk[10:0] = '1; end
        fl = '{hc, hs, vs, de, fs, lk};
        for (int i = 0; i < 6; i++) begin
            if (fl[i] >= 0) begin
                r.exp[28-i] = fl[i][0];
                r.msk[28-i] = 1'b1;
            end
        end
        r.chk = (r.msk != '0);
        return r;
    endfunction

    function automatic vec_t FE(int k);
        return V(k, "fe", -1, -1, -1, -1, -1, -1, -1, -1, 1'b0, 1'b1);
    endfunction

    task automatic compare_now(input int k);
        vec_t        e;
        logic [28:0] act;
        while (sb.size() > 0 && sb[0].k <= k) begin
            e   = sb.pop_front();
            act = e.dut_b ? obs_b : obs_a;
            checks++;
            if (e.k != k || ((act & e.msk) != (e.exp & e.msk))) begin
                errors++;
                $display("FAIL %s %s k=%0d: actual %h required %h (mask %h)",
                         e.tag, e.dut_b ? "dut_b" : "dut_a", k,
                         act & e.msk, e.exp & e.msk, e.msk);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fe  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(V(0, "rst_a", 0, 0, 1, 0, 0, 0, 0, 0));
        sb.push_back(V(0, "rst_b", 0, 0, 1, 0, 0, 0, 0, 0, 1'b1));
        compare_now(0);
    endtask

    // Reset, then run last_k clocks applying pulses and checking vectors
    task automatic run(input vec_t tv[$], input int last_k);
        do_reset();
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            rst = 1'b0;
            fe  = 1'b0;
            foreach (tv[i]) begin
                if (tv[i].k == k) begin
                    if (tv[i].fe) fe = 1'b1;
                    if (tv[i].chk) sb.push_back(tv[i]);
                end
            end
            @(posedge clk);
            #1;
            compare_now(k);
        end
        @(negedge clk);
        fe = 1'b0;
    endtask

    vec_t ras[$];
    vec_t jmp[$];
    vec_t coin[$];
    vec_t two[$];
    vec_t conv[$];
    vec_t seq[$];
    int   first;

    initial begin
        // Free-running raster (pixel p shows at k = 2p+1) and CLK_DIV=4 divider
        ras.push_back(V(1,   "px0",      0, 0, 0, 0, 0, 1, 0, 0));
        ras.push_back(V(2,   "px0_clk",  0, 0, 1, -1, -1, -1, -1, -1));
        ras.push_back(V(31,  "de_last", 15, 0, -1, 0, 0, 1, -1, -1));
        ras.push_back(V(33,  "de_off",  16, 0, -1, 0, 0, 0, -1, -1));
        ras.push_back(V(35,  "hs_pre",  17, 0, -1, 0, -1, 0, -1, -1));
        ras.push_back(V(37,  "hs_on",   18, 0, -1, 1, -1, 0, -1, -1));
        ras.push_back(V(41,  "hs_last", 20, 0, -1, 1, -1, -1, -1, -1));
        ras.push_back(V(43,  "hs_off",  21, 0, -1, 0, -1, -1, -1, -1));
        ras.push_back(V(47,  "h_end",   23, 0, -1, 0, 0, 0, 0, -1));
        ras.push_back(V(49,  "h_wrap",   0, 1, -1, 0, 0, 1, 0, -1));
        ras.push_back(V(385, "v_blank",  0, 8, -1, 0, 0, 0, -1, -1));
        ras.push_back(V(439, "vs_on",    3, 9, -1, 0, 1, 0, -1, -1));
        ras.push_back(V(527, "vs_last", 23, 10, -1, 0, 1, 0, -1, -1));
        ras.push_back(V(529, "vs_off",   0, 11, -1, 0, 0, 0, -1, -1));
        ras.push_back(V(567, "hs_v11",  19, 11, -1, 1, 0, 0, -1, -1));
        ras.push_back(V(575, "f_end",   23, 11, -1, -1, -1, -1, 0, -1));
        ras.push_back(V(577, "f_start",  0, 0, -1, 0, 0, 1, 1, 0));
        ras.push_back(V(578, "fs_pulse", 0, 0, -1, -1, -1, -1, 0, -1));
        ras.push_back(V(1,  "bclk1", -1, -1, 1, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(2,  "bclk2", -1, -1, 0, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(3,  "bclk3", -1, -1, 0, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(4,  "bclk4",  0, -1, 1, 0, 0, -1, -1, -1, 1'b1));
        ras.push_back(V(5,  "bclk5",  1, -1, 1, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(6,  "bclk6", -1, -1, 0, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(7,  "bclk7", -1, -1, 0, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(8,  "bclk8",  1, -1, 1, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(9,  "bh2",    2, 0, -1, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(12, "bh2b",   2, 0, -1, -1, -1, -1, -1, -1, 1'b1));
        ras.push_back(V(13, "bh3",    3, 0, -1, -1, -1, -1, -1, -1, 1'b1));

        // Pulse at v=5,h=5: next wrap lands on line 0 instead of 6
        jmp.push_back(FE(251));
        jmp.push_back(V(285, "jmp_pre",  22, 5, -1, -1, -1, -1, -1, 0));
        jmp.push_back(V(287, "jmp_last", 23, 5, -1, 0, -1, 0, -1, 0));
        jmp.push_back(V(289, "jmp_to0",   0, 0, -1, -1, -1, 1, -1, 0));
        jmp.push_back(V(291, "jmp_h1",    1, 0, -1, -1, -1, -1, -1, 0));
        jmp.push_back(V(337, "jmp_next",  0, 1, -1, -1, -1, -1, -1, 0));

        // Pulse on the wrap pix_en of line 2: applied one line later
        coin.push_back(FE(144));
        coin.push_back(V(145, "coin_noj",  0, 3, -1, -1, -1, -1, -1, -1));
        coin.push_back(V(191, "coin_last", 23, 3, -1, -1, -1, -1, -1, -1));
        coin.push_back(V(193, "coin_jmp",  0, 0, -1, -1, -1, -1, -1, 0));

        // Two pulses within line 2: exactly one jump
        two.push_back(FE(103));
        two.push_back(FE(117));
        two.push_back(V(145, "two_jmp", 0, 0, -1, -1, -1, -1, -1, 0));
        two.push_back(V(193, "two_one", 0, 1, -1, -1, -1, -1, -1, 0));

        // In-phase pulses on line 11 of three consecutive frames
        conv.push_back(FE(539));
        conv.push_back(FE(1115));
        conv.push_back(FE(1691));
        conv.push_back(V(577,  "conv_f1", 0, 0, -1, -1, -1, -1, 1, 0));
        conv.push_back(V(1153, "conv_f2", 0, 0, -1, -1, -1, -1, 1, 0));
        conv.push_back(V(1728, "conv_pre", -1, -1, -1, -1, -1, -1, -1, 0));
        conv.push_back(V(1729, "conv_lock", 0, 0, -1, -1, -1, -1, 1, 1));
        conv.push_back(V(1729, "b_nolock", -1, -1, -1, -1, -1, -1, -1, 0,
                         1'b1));

        run(ras, 578);
        run(jmp, 337);
        run(coin, 193);
        run(two, 193);

        // Lock, then one off-phase pulse breaks it with a jump
        seq = conv;
        seq.push_back(FE(1979));
        seq.push_back(V(2015, "off_last", 23, 5, -1, -1, -1, -1, -1, 1));
        seq.push_back(V(2016, "off_hold", -1, -1, -1, -1, -1, -1, -1, 1));
        seq.push_back(V(2017, "off_jump", 0, 0, -1, -1, -1, -1, -1, 0));
        run(seq, 2017);

        // Lock, then reset mid-line while hsync is asserted
        seq = conv;
        seq.push_back(V(1765, "pre_rst", 18, 0, -1, 1, 0, 0, -1, 1));
        run(seq, 1765);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(V(0, "midline_rst", 0, 0, 1, 0, 0, 0, 0, 0));
        compare_now(0);

        first = 0;
        for (int k = 1; k <= 1000 && first == 0; k++) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            if (bus_a.o_frame_start) first = k;
        end
        checks++;
        if (first != 577) begin
            errors++;
            $display("FAIL first_fs: actual clk %0d required 577 (0 = none)",
                     first);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        sb.push_back(V(first + 1, "fs_width", -1, -1, -1, -1, -1, -1, 0, -1));
        compare_now(first + 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/hd_sync_gen.md
Name: hd_sync_gen

Overview:
- Generates the HD raster timing that drives the PAL-to-HD upsampler's HD-side inputs: the HD pixel-clock level, hsync, vsync and data-enable.
- Default raster is 1280x720p.
- Optionally genlocks its vertical position to the upsampler's PAL frame-end pulse, so HD frames track PAL frames without drift.
- Sits between the upsampler and the ADV7511 output stage, in the same clk domain as the upsampler.

Parameters:
CLK_DIV, 2, clk cycles per HD pixel; even, >=2
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync
GENLOCK_EN, 1, 1 = honour i_frame_end
LOCK_LINE, 0, v_count value forced on genlock

Ports:
clk  in  1  system clock, same as upsampler clk
i_rst  in  1  synchronous reset, active-high
i_frame_end  in  1  one-clk pulse per PAL frame (upsampler o_frame_end)
o_hd_clk  out  1  HD pixel clock as a level; high for div_cnt < CLK_DIV/2
o_hd_hsync  out  1  horizontal sync, polarity HS_POL
o_hd_vsync  out  1  vertical sync, polarity VS_POL
o_hd_de  out  1  high in active area
o_h_count  out  12  current pixel index
o_v_count  out  11  current line index
o_frame_start  out  1  one-clk pulse when raster wraps to (0,0)
o_locked  out  1  genlock stable

Behaviour:
- Single clock domain: clk. i_rst is synchronous and active-high. It is sampled every clk and overrides everything else.
- Reset values:
  - div_cnt=0, h_count=0, v_count=0, pending=0, lock_cnt=0.
  - o_hd_clk=1, o_hd_hsync=~HS_POL, o_hd_vsync=~VS_POL, o_hd_de=0, o_frame_start=0, o_locked=0.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - pix_en is high when div_cnt==CLK_DIV-1.
  - o_hd_clk is registered as (next div_cnt < CLK_DIV/2).
- Horizontal counter:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On pix_en, h_count increments; at H_TOTAL-1 it wraps to 0 (line wrap).
- Vertical counter:
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - On line wrap, v_count increments; at V_TOTAL-1 it wraps to 0.
- Decode, all outputs registered, valid 1 clk after the counter update:
  - de = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, whole lines.
  - o_frame_start pulses 1 clk on the pix_en where both h and v wrap to 0.
  - o_h_count and o_v_count follow the counters.
- Genlock FSM, states IDLE and PENDING:
  - IDLE: i_frame_end && GENLOCK_EN moves to PENDING.
  - PENDING: a further i_frame_end merges, with no second action.
  - PENDING, at the next line wrap: the natural next v is compared with LOCK_LINE.
    - Equal: no jump; lock_cnt increments, saturating at 3.
    - Not equal: v_count <= LOCK_LINE; lock_cnt <= 0.
    - Either way, return to IDLE.
  - If i_frame_end coincides with a line-wrap pix_en, it is latched and applied at the following line wrap, never the same cycle.
  - o_locked = (lock_cnt==3), registered.
  - GENLOCK_EN=0: FSM stays in IDLE and o_locked stays 0.
- Jump semantics: a forced v_count takes effect exactly at the line boundary. h_count is never modified by genlock, so no partial or runt lines are produced.
- Reset mid-frame: next clk returns all outputs to reset values. Raster restarts at (0,0), and the first o_frame_start occurs after one full frame.
- Widths: h_count 12 bits and v_count 11 bits. H_TOTAL must be <=4096 and V_TOTAL <=2048; anything larger is a parameter error, with no runtime check.

Test Plan:
- Reset and divider: CLK_DIV=4; release reset -> o_hd_clk pattern 1,1,0,0 repeating; h_count increments every 4 clk; all syncs inactive and de=0 during reset.
- Horizontal timing: small raster H=16/2/3/3 (H_TOTAL 24), CLK_DIV=2 -> de high 16 pixels, hsync asserted h=18..20, h_count wraps 23->0, line period 48 clk.
- Vertical timing: V=8/1/2/1 (V_TOTAL 12) -> vsync asserted lines 9..10; o_frame_start one-clk pulse every 24*12*2=576 clk; de low on lines 8..11.
- Genlock jump: LOCK_LINE=0; pulse i_frame_end while v=5 -> at the next line wrap v_count becomes 0, not 6; o_locked=0; no h_count discontinuity.
- Genlock convergence: pulse i_frame_end at each line wrap preceding v=LOCK_LINE, 3 frames in a row -> lock_cnt 1,2,3, with o_locked rising after the third; then pulse off-phase once -> o_locked falls and a jump occurs.
- Edge cases:
  - i_frame_end coincident with a line-wrap pix_en -> applied one line later.
  - Two pulses within one line -> single jump.
  - i_rst asserted mid-line -> next clk outputs match reset values and o_locked=0.
